frac_clk_gen: RTL and testbench

Parametrised fractional clock-enable generator: the soft successor to the fixed-frequency board PLL wrappers. It derives NUM_CLOCKS independently programmable clock enables and square-wave outputs from one reference clock, using phase accumulators. It sits beside the PLL and provides run-time retunable rates, such as emulated machine clocks and peripheral ticks, plus a PLL-style `locked` indication that drops and re-settles on every reconfiguration.

---
 rtl/frac_clk_gen.sv | 154 +++++++++++++++
 tb/tb_frac_clk_gen.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frac_clk_gen.sv
// Fractional clock-enable generator: NUM_CLOCKS phase accumulators with run-time
// programmable increments and a PLL-style lock indication that re-settles on each retune.
module frac_clk_gen #(
  parameter int NUM_CLOCKS  = 3,
  parameter int ACC_WIDTH   = 32,
  parameter int LOCK_CYCLES = 1024,
  parameter logic [NUM_CLOCKS*ACC_WIDTH-1:0] INIT_INC = '0
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [3:0]            cfg_chan,
  input  logic [ACC_WIDTH-1:0]  cfg_inc,
  input  logic                  cfg_sync,
  output logic [NUM_CLOCKS-1:0] clken,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic                  locked
);

  localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [4:0] NUM_CLK_W = 5'(NUM_CLOCKS);

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_IDLE   = 2'd1,
    ST_APPLY  = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [CNT_W-1:0]     cnt_nxt_s;
  logic [3:0]           chan_r;
  logic [ACC_WIDTH-1:0] inc_req_r;
  logic                 sync_r;
  logic                 ready_r;
  logic                 locked_r;
  logic                 accept_s;
  logic                 apply_s;
  logic                 chan_valid_s;
  logic                 ready_nxt_s;
  logic                 locked_nxt_s;

  assign chan_valid_s = ({1'b0, chan_r} < NUM_CLK_W);

  // State register, settle counter and request latch
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_SETTLE;
      cnt_r     <= '0;
      chan_r    <= 4'd0;
      inc_req_r <= '0;
      sync_r    <= 1'b0;
      ready_r   <= 1'b0;
      locked_r  <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= cnt_nxt_s;
      ready_r  <= ready_nxt_s;
      locked_r <= locked_nxt_s;
      if (accept_s) begin
        chan_r    <= cfg_chan;
        inc_req_r <= cfg_inc;
        sync_r    <= cfg_sync;
      end
    end
  end

  // Next-state logic; a no-op request (bad channel, no sync) skips the settle phase
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_SETTLE: begin
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = '0;
        end else begin
          cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_IDLE: begin
        if (cfg_valid && ready_r) begin
          state_nxt_s = ST_APPLY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_APPLY: begin
        cnt_nxt_s = '0;
        if (chan_valid_s || sync_r) begin
          state_nxt_s = ST_SETTLE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_SETTLE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // Output decode; locked stays up through APPLY so it falls one edge after the handshake
  always_comb begin
    accept_s     = (state_r == ST_IDLE) && cfg_valid && ready_r;
    apply_s      = (state_r == ST_APPLY);
    ready_nxt_s  = (state_nxt_s == ST_IDLE);
    locked_nxt_s = (state_nxt_s != ST_SETTLE);
  end

  assign cfg_ready = ready_r;
  assign locked    = locked_r;

  for (genvar g = 0; g < NUM_CLOCKS; g++) begin : g_chan
    localparam logic [3:0] IDX = 4'(g);
    logic [ACC_WIDTH-1:0] acc_r;
    logic [ACC_WIDTH-1:0] inc_r;
    logic                 clken_r;
    logic [ACC_WIDTH:0]   sum_s;
    logic                 write_s;
    logic                 clear_s;

    assign sum_s   = {1'b0, acc_r} + {1'b0, inc_r};
    assign write_s = apply_s && (chan_r == IDX);
    assign clear_s = write_s || (apply_s && sync_r);

    // Phase accumulator; an APPLY clear overrides a coincident carry
    always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
        acc_r   <= '0;
        inc_r   <= INIT_INC[g*ACC_WIDTH +: ACC_WIDTH];
        clken_r <= 1'b0;
      end else begin
        if (clear_s) begin
          acc_r   <= '0;
          clken_r <= 1'b0;
        end else begin
          acc_r   <= sum_s[ACC_WIDTH-1:0];
          clken_r <= sum_s[ACC_WIDTH];
        end
        if (write_s) begin
          inc_r <= inc_req_r;
        end
      end
    end

    assign clken[g]  = clken_r;
    assign outclk[g] = acc_r[ACC_WIDTH-1];
  end

endmodule

// File: tb/tb_frac_clk_gen.sv
// Bench for frac_clk_gen: directed scenarios plus random retunes, checked every cycle
// against an arithmetic model of rates, wraps and lock timing.
module tb_frac_clk_gen;

  localparam int NCH  = 3;
  localparam int AW   = 32;
  localparam int LOCK = 4;
  localparam logic [NCH*AW-1:0] INIT = {32'h0000_0000, 32'h0000_0000, 32'h8000_0000};
  localparam longint TWO32 = 64'h1_0000_0000;
  localparam longint TWO31 = 64'h8000_0000;

  logic           refclk;
  logic           rst_n;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [3:0]     cfg_chan;
  logic [AW-1:0]  cfg_inc;
  logic           cfg_sync;
  logic [NCH-1:0] clken;
  logic [NCH-1:0] outclk;
  logic           locked;

  frac_clk_gen #(
    .NUM_CLOCKS (NCH),
    .ACC_WIDTH  (AW),
    .LOCK_CYCLES(LOCK),
    .INIT_INC   (INIT)
  ) dut (
    .refclk   (refclk),
    .rst_n    (rst_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan (cfg_chan),
    .cfg_inc  (cfg_inc),
    .cfg_sync (cfg_sync),
    .clken    (clken),
    .outclk   (outclk),
    .locked   (locked)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  longint m_acc [NCH];
  longint m_inc [NCH];
  bit     m_clken [NCH];
  bit     m_locked, m_ready, m_pending, m_hs;
  int     m_rise;
  int     edge_n;
  int     q_chan;
  longint q_inc;
  bit     q_sync;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_acc[i]   = 0;
      m_inc[i]   = longint'(INIT[i*AW +: AW]);
      m_clken[i] = 1'b0;
    end
    m_locked  = 1'b0;
    m_ready   = 1'b0;
    m_pending = 1'b0;
    m_hs      = 1'b0;
    m_rise    = LOCK;
    edge_n    = 0;
  endtask

  // one refclk edge: advance model, then compare every output
  task automatic step();
    bit             hs_now;
    longint         s;
    logic [NCH-1:0] e_clken;
    logic [NCH-1:0] e_out;
    @(posedge refclk);
    edge_n++;
    hs_now = cfg_valid && m_ready;
    m_hs   = hs_now;
    for (int i = 0; i < NCH; i++) begin
      s          = m_acc[i] + m_inc[i];
      m_clken[i] = (s >= TWO32);
      m_acc[i]   = s % TWO32;
    end
    if (m_pending) begin
      m_pending = 1'b0;
      if (q_chan < NCH) begin
        m_inc[q_chan]   = q_inc;
        m_acc[q_chan]   = 0;
        m_clken[q_chan] = 1'b0;
      end
      if (q_sync) begin
        for (int i = 0; i < NCH; i++) begin
          m_acc[i]   = 0;
          m_clken[i] = 1'b0;
        end
      end
      if (q_chan < NCH || q_sync) begin
        m_locked = 1'b0;
        m_ready  = 1'b0;
        m_rise   = edge_n + LOCK;
      end else begin
        m_ready = 1'b1;
      end
    end
    if (edge_n == m_rise) begin
      m_locked = 1'b1;
      m_ready  = 1'b1;
    end
    if (hs_now) begin
      m_pending = 1'b1;
      q_chan    = int'(cfg_chan);
      q_inc     = longint'(cfg_inc);
      q_sync    = cfg_sync;
      m_ready   = 1'b0;
    end
    #1;
    for (int i = 0; i < NCH; i++) begin
      e_clken[i] = m_clken[i];
      e_out[i]   = (m_acc[i] >= TWO31);
    end
    chk("clken", 64'(clken), 64'(e_clken));
    chk("outclk", 64'(outclk), 64'(e_out));
    chk("locked", 64'(locked), 64'(m_locked));
    chk("cfg_ready", 64'(cfg_ready), 64'(m_ready));
  endtask

  task automatic request(input logic [3:0] ch, input logic [AW-1:0] inc, input logic sy,
                         output int hs);
    cfg_chan  = ch;
    cfg_inc   = inc;
    cfg_sync  = sy;
    cfg_valid = 1'b1;
    hs        = -1;
    for (int k = 0; k < 50 && hs < 0; k++) begin
      step();
      if (m_hs) hs = edge_n;
    end
    cfg_valid = 1'b0;
    chk("handshake_seen", 64'(hs >= 0), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_clken"}, 64'(clken), 64'd0);
    chk({tag, "_outclk"}, 64'(outclk), 64'd0);
    chk({tag, "_locked"}, 64'(locked), 64'd0);
    chk({tag, "_ready"}, 64'(cfg_ready), 64'd0);
  endtask

  int hs, hs2, first1, lowcnt, pulses, adjacent, diffcnt, rise_at;
  bit prev;

  initial begin
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_chan  = 4'd0;
    cfg_inc   = '0;
    cfg_sync  = 1'b0;
    model_reset();
    repeat (3) @(posedge refclk);
    #1;
    check_all_zero("reset");
    @(negedge refclk);
    rst_n = 1'b1;

    // reset release: lock at edge LOCK, ch0 at half rate
    rise_at = -1;
    for (int k = 0; k < 8; k++) begin
      step();
      if (locked && rise_at < 0) rise_at = edge_n;
    end
    chk("lock_after_reset_edge", 64'(rise_at), 64'(LOCK));

    // ch1 = quarter rate
    request(4'd1, 32'h4000_0000, 1'b0, hs);
    first1 = -1;
    lowcnt = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (clken[1] && first1 < 0) first1 = edge_n;
      if (!locked) lowcnt++;
    end
    chk("ch1_first_pulse_edge", 64'(first1), 64'(hs + 5));
    chk("locked_low_cycles", 64'(lowcnt), 64'(LOCK));

    // ch2 = one third rate
    request(4'd2, 32'h5555_5556, 1'b0, hs);
    pulses   = 0;
    adjacent = 0;
    prev     = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      step();
      if (clken[2]) pulses++;
      if (clken[2] && prev) adjacent++;
      prev = clken[2];
    end
    chk("ch2_pulse_count_ok", 64'(pulses >= 999 && pulses <= 1001), 64'd1);
    chk("ch2_adjacent_pulses", 64'(adjacent), 64'd0);

    // sync: ch0 matches ch1 rate, all accumulators restart together
    request(4'd0, 32'h4000_0000, 1'b1, hs);
    step();
    chk("sync_outclk_zero", 64'(outclk), 64'd0);
    // out-of-range request held through SETTLE
    request(4'd7, 32'h1234_5678, 1'b0, hs2);
    chk("held_request_edge", 64'(hs2), 64'(hs + LOCK + 2));
    diffcnt = 0;
    lowcnt  = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (clken[0] != clken[1]) diffcnt++;
      if (!locked) lowcnt++;
    end
    chk("sync_coincident_diff_cycles", 64'(diffcnt), 64'd0);
    chk("noop_locked_low_cycles", 64'(lowcnt), 64'd0);

    // random retunes
    for (int r = 0; r < 12; r++) begin
      request(4'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 3) == 0), hs);
      repeat ($urandom_range(1, 12)) step();
    end

    // reset in the middle of SETTLE
    request(4'd1, 32'h2000_0000, 1'b0, hs);
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(negedge refclk);
    rst_n = 1'b1;
    rise_at = -1;
    for (int k = 0; k < 12; k++) begin
      step();
      if (locked && rise_at < 0) rise_at = edge_n;
    end
    chk("relock_edge", 64'(rise_at), 64'(LOCK));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
